// File: rtl/host_mem_pkg.sv
// host_mem_pkg: shared constants, FSM state type and byte-lane helpers for the host memory loader
package host_mem_pkg;

    localparam int DEPTH = 7168;
    localparam int AW    = 13;
    localparam int LW    = 16;

    typedef enum logic [2:0] {IDLE, CHECK, FILL, WRITE, FINISH} state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [2:0] be_bytes(input logic [3:0] be);
        return {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
    endfunction

endpackage

// File: rtl/host_mem_packer.sv
// host_mem_packer: little-endian byte-to-word lane buffer with byteenable tracking
module host_mem_packer
    import host_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic [1:0]  lane
);

    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lane_q, lane_d;

    // clear wins over push so a discarded word never picks up a stray byte
    always_comb begin
        data_d = data_q;
        be_d   = be_q;
        lane_d = lane_q;
        if (clr) begin
            data_d = '0;
            be_d   = '0;
            lane_d = '0;
        end else if (push) begin
            data_d[{lane_q, 3'b000} +: 8] = din;
            be_d   = be_q | lane_be(lane_q);
            lane_d = lane_q + 2'd1;
        end
    end

    // lane buffer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            be_q   <= '0;
            lane_q <= '0;
        end else begin
            data_q <= data_d;
            be_q   <= be_d;
            lane_q <= lane_d;
        end
    end

    assign data = data_q;
    assign be   = be_q;
    assign lane = lane_q;

endmodule

// File: rtl/host_mem_loader.sv
// host_mem_loader: packs a byte stream into 32-bit words and writes them to host memory
module host_mem_loader
    import host_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    input  logic          mem_grant,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [LW-1:0] byte_count,
    output logic [15:0]   checksum
);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             error_q, error_d;
    logic [LW-1:0]    byte_count_q, byte_count_d;
    logic [15:0]      checksum_q, checksum_d;
    logic             push, clr;
    logic [31:0]      pk_data;
    logic [3:0]       pk_be;
    logic [1:0]       pk_lane;
    logic [LW:0]      words;
    logic [AW+LW-1:0] end_w;
    logic [15:0]      byte_sum;
    logic             oob;

    host_mem_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .din   (s_data),
        .data  (pk_data),
        .be    (pk_be),
        .lane  (pk_lane)
    );

    // bounds are evaluated wide enough that base + words can never wrap
    assign words    = ({1'b0, len_q} + 17'd3) >> 2;
    assign end_w    = {{LW{1'b0}}, addr_q} + {{(AW-1){1'b0}}, words};
    assign oob      = end_w > (AW+LW)'(DEPTH);
    assign byte_sum = {8'h00, pk_data[7:0]} + {8'h00, pk_data[15:8]}
                    + {8'h00, pk_data[23:16]} + {8'h00, pk_data[31:24]};

    // next-state, counters and bus strobes; unused lanes are zero so summing all lanes is exact
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        rem_d          = rem_q;
        error_d        = error_q;
        byte_count_d   = byte_count_q;
        checksum_d     = checksum_q;
        s_ready        = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        done           = 1'b0;
        push           = 1'b0;
        clr            = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d      = CHECK;
                addr_d       = base_addr;
                len_d        = length;
                rem_d        = length;
                error_d      = 1'b0;
                byte_count_d = '0;
                checksum_d   = '0;
            end
            CHECK: begin
                state_d = (abort || len_q == '0 || oob) ? FINISH : FILL;
                error_d = abort || (len_q != '0 && oob);
            end
            FILL: begin
                s_ready = 1'b1;
                if (abort) begin
                    state_d = FINISH;
                    error_d = 1'b1;
                    clr     = 1'b1;
                end else if (s_valid) begin
                    push    = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (pk_lane == 2'd3 || rem_q == 1) ? WRITE : FILL;
                end
            end
            WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                if (mem_grant) begin
                    byte_count_d = byte_count_q + {{(LW-3){1'b0}}, be_bytes(pk_be)};
                    checksum_d   = checksum_q + byte_sum;
                    addr_d       = addr_q + 1'b1;
                    clr          = 1'b1;
                    state_d      = (rem_q != '0) ? FILL : FINISH;
                end
                if (abort) begin
                    state_d = FINISH;
                    error_d = 1'b1;
                    clr     = 1'b1;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // control state and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            error_q      <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            error_q      <= error_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_writedata  = pk_data;
    assign mem_byteenable = pk_be;
    assign busy           = state_q != IDLE;
    assign error          = error_q;
    assign byte_count     = byte_count_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_host_mem_loader.sv
// tb_host_mem_loader: scoreboard bench for the host memory loader
module tb_host_mem_loader;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [12:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        abort = 0;
    logic        s_valid = 0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        mem_grant = 1;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] byte_count;
    logic [15:0] checksum;

    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];
    wr_t  got_e;
    logic [15:0] exp_cnt, exp_sum;
    logic        exp_err;

    host_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .mem_grant      (mem_grant),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .byte_count     (byte_count),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // a granted write seen at the falling edge commits on the next rising edge
    always @(negedge clk) begin
        if (!reset && mem_write && mem_grant) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h be=%h, required none", mem_address, mem_writedata, mem_byteenable);
            end else begin
                got_e = exp_q.pop_front();
                if ({mem_address, mem_writedata, mem_byteenable} !== got_e) begin
                    fails++;
                    $display("FAIL write: got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                             mem_address, mem_writedata, mem_byteenable, got_e.addr, got_e.data, got_e.be);
                end
            end
        end
    end

    task automatic model(input logic [12:0] base, input logic [15:0] len, input logic [7:0] first, input int abort_after);
        int   words;
        int   eff;
        logic [7:0] b;
        wr_t  w;
        words   = (int'(len) + 3) / 4;
        exp_cnt = '0;
        exp_sum = '0;
        exp_err = (len != 0 && int'(base) + words > 7168) || abort_after >= 0;
        if (len == 0 || int'(base) + words > 7168) eff = 0;
        else eff = (abort_after >= 0) ? (abort_after / 4) * 4 : int'(len);
        w = '0;
        w.addr = base;
        for (int i = 0; i < eff; i++) begin
            b = 8'(int'(first) + i);
            w.data[(i % 4) * 8 +: 8] = b;
            w.be[i % 4] = 1'b1;
            exp_sum = exp_sum + {8'h00, b};
            exp_cnt = exp_cnt + 16'd1;
            if (i % 4 == 3 || i == eff - 1) begin
                exp_q.push_back(w);
                w.addr = w.addr + 13'd1;
                w.data = '0;
                w.be   = '0;
            end
        end
    endtask

    task automatic pulse_start(input logic [12:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        base_addr = base;
        length    = len;
        start     = 1;
        @(posedge clk); #1;
        start     = 0;
    endtask

    task automatic feed(input logic [7:0] first, input int n, input int abort_after);
        int   i = 0;
        int   cyc = 0;
        logic acc;
        s_data  = first;
        s_valid = (n > 0);
        while (i < n && cyc < 500) begin
            if (abort_after >= 0 && i == abort_after) break;
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                s_data = 8'(int'(first) + i);
            end
            cyc++;
        end
        s_valid = 0;
        tests++;
        if (cyc >= 500) begin
            fails++;
            $display("FAIL feed_timeout: got %0d bytes accepted, required %0d", i, n);
        end
        if (abort_after >= 0) begin
            abort = 1;
            @(posedge clk); #1;
            abort = 0;
        end
    endtask

    task automatic wait_done(input string name);
        int   cyc = 0;
        logic seen = 0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            seen = done;
            cyc++;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL %s done_timeout: got no done, required done pulse", name); end
        tests++;
        if (error !== exp_err) begin fails++; $display("FAIL %s error: got %b, required %b", name, error, exp_err); end
        tests++;
        if (byte_count !== exp_cnt) begin fails++; $display("FAIL %s byte_count: got %0d, required %0d", name, byte_count, exp_cnt); end
        tests++;
        if (checksum !== exp_sum) begin fails++; $display("FAIL %s checksum: got %h, required %h", name, checksum, exp_sum); end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL %s idle_after_done: got busy=%b done=%b, required 0 0", name, busy, done); end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s missing_writes: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({s_ready, mem_chipselect, mem_write, mem_byteenable, done, error, busy} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got s_ready=%b cs=%b wr=%b be=%h done=%b err=%b busy=%b, required all 0",
                     s_ready, mem_chipselect, mem_write, mem_byteenable, done, error, busy);
        end
        tests++;
        if ({mem_address, mem_writedata, byte_count, checksum} !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h data=%h cnt=%h sum=%h, required all 0", mem_address, mem_writedata, byte_count, checksum);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_aligned();
        mem_grant = 1;
        model(13'h10, 16'd8, 8'h01, -1);
        pulse_start(13'h10, 16'd8);
        feed(8'h01, 8, -1);
        wait_done("aligned");
    endtask

    task automatic test_partial();
        model(13'h0, 16'd6, 8'hAA, -1);
        pulse_start(13'h0, 16'd6);
        feed(8'hAA, 6, -1);
        wait_done("partial");
    endtask

    task automatic test_bounds();
        model(13'd7167, 16'd5, 8'h00, -1);
        pulse_start(13'd7167, 16'd5);
        wait_done("bounds_over");
        model(13'd7167, 16'd4, 8'h11, -1);
        pulse_start(13'd7167, 16'd4);
        feed(8'h11, 4, -1);
        wait_done("bounds_fit");
    endtask

    task automatic test_grant_stall();
        logic [12:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        mem_grant = 0;
        model(13'h20, 16'd4, 8'h40, -1);
        pulse_start(13'h20, 16'd4);
        feed(8'h40, 4, -1);
        s_valid = 1;
        s_data  = 8'hEE;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
            fails++;
            $display("FAIL stall_strobe_latency: got wr=%b cs=%b, required 1 1", mem_write, mem_chipselect);
        end
        a0 = mem_address;
        d0 = mem_writedata;
        b0 = mem_byteenable;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({mem_address, mem_writedata, mem_byteenable} !== {a0, d0, b0} || s_ready !== 1'b0 || mem_write !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold: got addr=%h data=%h be=%h rdy=%b wr=%b, required addr=%h data=%h be=%h rdy=0 wr=1",
                         mem_address, mem_writedata, mem_byteenable, s_ready, mem_write, a0, d0, b0);
            end
        end
        @(posedge clk); #1;
        mem_grant = 1;
        s_valid   = 0;
        wait_done("grant_stall");
    endtask

    task automatic test_abort();
        mem_grant = 1;
        model(13'h100, 16'd12, 8'h50, 6);
        pulse_start(13'h100, 16'd12);
        feed(8'h50, 12, 6);
        wait_done("abort");
    endtask

    task automatic test_async_reset();
        mem_grant = 0;
        pulse_start(13'h30, 16'd4);
        feed(8'h60, 4, -1);
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b1) begin fails++; $display("FAIL areset_pre: got mem_write=%b, required 1", mem_write); end
        #2;
        reset = 1;
        #1;
        tests++;
        if ({mem_write, mem_chipselect, s_ready, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL areset_ctrl: got wr=%b cs=%b rdy=%b busy=%b done=%b err=%b, required all 0",
                     mem_write, mem_chipselect, s_ready, busy, done, error);
        end
        tests++;
        if ({mem_address, mem_writedata, mem_byteenable, byte_count, checksum} !== '0) begin
            fails++;
            $display("FAIL areset_data: got addr=%h data=%h be=%h cnt=%h sum=%h, required all 0",
                     mem_address, mem_writedata, mem_byteenable, byte_count, checksum);
        end
        @(posedge clk); #1;
        reset     = 0;
        mem_grant = 1;
    endtask

    task automatic test_zero_len();
        model(13'h5, 16'd0, 8'h00, -1);
        pulse_start(13'h5, 16'd0);
        wait_done("zero_len");
    endtask

    task automatic test_back_to_back();
        model(13'h200, 16'd7, 8'hF8, -1);
        pulse_start(13'h200, 16'd7);
        feed(8'hF8, 7, -1);
        wait_done("b2b_first");
        model(13'h300, 16'd9, 8'h7F, -1);
        pulse_start(13'h300, 16'd9);
        feed(8'h7F, 9, -1);
        wait_done("b2b_second");
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_partial();
        test_bounds();
        test_grant_stall();
        test_abort();
        test_async_reset();
        test_zero_len();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/host_mem_loader.md
Name: host_mem_loader

Overview:
- Upstream write-side feeder for the 7168 x 32-bit single-port host memory.
- Accepts a byte stream, e.g. a cartridge image from the SD sector reader, and packs bytes little-endian into 32-bit words.
- Writes each word into host memory at consecutive word addresses using the memory's chipselect/write/byteenable slave port.
- Reports completion, error, byte count and a running checksum to the control CPU.

Parameters:
- DEPTH, 7168, number of 32-bit words in host memory.
- AW, 13, word address width.
- LW, 16, width of the byte-length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; latches base_addr and length. Ignored unless in IDLE.
- base_addr  in  AW  first word address of the load.
- length  in  LW  number of bytes to load.
- abort  in  1  synchronous cancel.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  byte accepted when s_valid & s_ready are both high.
- mem_grant  in  1  arbiter grant; a write completes on any clock edge where mem_write=1 and mem_grant=1.
- mem_address  out  AW  word address.
- mem_byteenable  out  4  lanes to write.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  packed word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky status of the last operation; cleared by the next accepted start.
- byte_count  out  LW  bytes committed to memory.
- checksum  out  16  sum of committed bytes, mod 2^16.

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0, including s_ready, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_address, done, error, byte_count and checksum.
  - Reset asserted mid-operation drops mem_write immediately (asynchronously), discards any partial word and returns to IDLE.
- States: IDLE, CHECK, FILL, WRITE, FINISH.
- IDLE + start:
  - Latch base_addr and length.
  - Clear error, byte_count and checksum.
  - Next state is CHECK.
- CHECK, one cycle:
  - words = ceil(length/4).
  - If length==0 -> FINISH, error=0, no writes.
  - Else if base_addr + words > DEPTH (compute at AW+LW width, no wrap) -> FINISH, error=1, no writes.
  - Else -> FILL.
- FILL:
  - s_ready = 1 while bytes remain.
  - Each accepted byte goes to lane (byte index mod 4); lane 0 is writedata[7:0].
  - Byteenable bit for that lane is set.
  - On the 4th lane, or on the final byte of length -> WRITE in the next cycle.
- WRITE:
  - s_ready = 0.
  - mem_chipselect = mem_write = 1, holding address, data and byteenable stable until mem_grant=1.
  - On a granted edge:
    - Add the enabled bytes to byte_count and checksum.
    - Increment the address.
    - Clear the pack buffer.
    - Next state is FILL if bytes remain, else FINISH.
- FINISH: done = 1 for one cycle -> IDLE.
- Partial final word: only the filled lanes are enabled, e.g. length=6 gives a second word with byteenable=4'b0011. Unused data lanes are 0.
- Latency and throughput:
  - 4th byte accepted on edge N -> write strobe visible in cycle N+1.
  - With mem_grant held at 1, 4 bytes commit every 5 cycles.
- Address arithmetic never wraps; the CHECK state guarantees the last address is DEPTH-1 or lower.
- abort in CHECK, FILL or WRITE:
  - Next state is FINISH with error=1; the partial word is discarded.
  - If abort coincides with a granted write edge, that write counts as committed.
  - abort in IDLE or FINISH is ignored.
- start while busy is ignored.
- s_valid while s_ready=0 is not consumed.

Decomposition:
- Shared package host_mem_pkg:
  - DEPTH and AW constants.
  - State enum type.
  - Byteenable/lane helper function.
- Natural sub-module: host_mem_packer.
  - Byte-to-word shift/lane buffer with lane count, byteenable and clear.
  - FSM, counters and bus drive stay in host_mem_loader.

Test Plan:
- Aligned load:
  - Stimulus: base=0x10, length=8, bytes 01..08, mem_grant=1.
  - Response: two writes: addr 0x10 data 0x04030201 be 4'hF, then addr 0x11 data 0x08070605 be 4'hF.
  - Response: done pulse, byte_count=8, checksum=0x0024, error=0.
- Partial tail:
  - Stimulus: base=0, length=6, bytes AA..AF.
  - Response: second write at addr 1, data 0x0000AFAE, be 4'b0011, byte_count=6.
- Bounds:
  - Stimulus 1: base=7167, length=5.
  - Response 1: no mem_write, done, error=1.
  - Stimulus 2: base=7167, length=4.
  - Response 2: one write at 7167, error=0.
- Grant stall:
  - Stimulus: mem_grant held 0 for 3 cycles during WRITE.
  - Response: address, data and byteenable stable and s_ready=0 throughout; a single write on the grant edge.
- Abort:
  - Stimulus: length=12, abort after 6 bytes.
  - Response: one committed word, partial word dropped, done, error=1, byte_count=4.
- Async reset and edge cases:
  - Reset during WRITE -> mem_write drops without a clock edge; outputs return to reset values.
  - length=0 -> done with no writes and error=0.
